// File: rtl/ysyx_23060278_pkg.sv
// Shared constants for the ysyx_23060278 multi-cycle sequencer: the FSM
// state encodings and the default memory-response timeout.
package ysyx_23060278_pkg;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_IWAIT = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_MWAIT = 3'd3;
  localparam logic [2:0] ST_WB    = 3'd4;
  localparam logic [2:0] ST_HALT  = 3'd5;

  localparam int TIMEOUT_DEFAULT = 255;

  // A legal memory instruction is exactly one of load or store.
  function automatic logic is_mem_op(input logic load, input logic store);
    return load ^ store;
  endfunction

endpackage

// File: rtl/ysyx_23060278_wdog.sv
// Wait-cycle counter for the memory wait states. It is held at zero outside
// a wait state and flags expiry on the TIMEOUT-th consecutive waiting cycle.
module ysyx_23060278_wdog
  import ysyx_23060278_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !wait_en) cnt <= '0;
    else                 cnt <= cnt + CW'(1);
  end

  // cnt counts completed waiting cycles, so the current cycle is number cnt+1.
  assign expired = wait_en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ysyx_23060278_seq.sv
// Multi-cycle instruction sequencer: fetch, execute, optional data access and
// write-back, with a response watchdog and an absorbing halt state.
//
// state | meaning
// FETCH | issue one-cycle instruction fetch request
// IWAIT | wait for instruction data, latch it into IR on arrival
// EXEC  | decode outcome selects memory access, write-back or halt
// MWAIT | wait for data-memory acknowledge
// WB    | update PC, optional register write, count retirement
// HALT  | stopped until reset; err tells why
module ysyx_23060278_seq
  import ysyx_23060278_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_rvalid,
  output logic        ir_we,
  input  logic        dec_regwrite,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_ebreak,
  output logic        dmem_req,
  output logic        dmem_wen,
  input  logic        dmem_ack,
  output logic        pc_we,
  output logic        rf_we,
  output logic        halt,
  output logic        err,
  output logic [31:0] retire_cnt,
  output logic [2:0]  state_o
);

  logic [2:0]  state, state_nx;
  logic        err_nx;
  logic        wait_en, expired;
  logic [31:0] retire_q;

  assign wait_en = (state == ST_IWAIT) || (state == ST_MWAIT);

  ysyx_23060278_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .wait_en (wait_en),
    .expired (expired)
  );

  // A response in the expiry cycle wins over the timeout.
  always_comb begin
    state_nx = state;
    err_nx   = err;
    case (state)
      ST_FETCH: state_nx = ST_IWAIT;
      ST_IWAIT: begin
        if (imem_rvalid) state_nx = ST_EXEC;
        else if (expired) begin
          state_nx = ST_HALT;
          err_nx   = 1'b1;
        end
      end
      ST_EXEC: begin
        if (dec_ebreak) state_nx = ST_HALT;
        else if (dec_load && dec_store) begin
          state_nx = ST_HALT;
          err_nx   = 1'b1;
        end
        else if (dec_load || dec_store) state_nx = ST_MWAIT;
        else                            state_nx = ST_WB;
      end
      ST_MWAIT: begin
        if (dmem_ack) state_nx = ST_WB;
        else if (expired) begin
          state_nx = ST_HALT;
          err_nx   = 1'b1;
        end
      end
      ST_WB:   state_nx = ST_FETCH;
      ST_HALT: state_nx = ST_HALT;
      default: begin
        state_nx = ST_HALT;
        err_nx   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH;
      err      <= 1'b0;
      retire_q <= '0;
    end else begin
      state <= state_nx;
      err   <= err_nx;
      if (state == ST_WB) retire_q <= retire_q + 32'd1;
    end
  end

  // Strobes are suppressed while rst is held so the first fetch follows release.
  assign imem_req   = !rst && (state == ST_FETCH);
  assign ir_we      = !rst && (state == ST_IWAIT) && imem_rvalid;
  assign dmem_req   = !rst && (state == ST_EXEC) && !dec_ebreak
                      && is_mem_op(dec_load, dec_store);
  assign dmem_wen   = dmem_req && dec_store;
  assign pc_we      = !rst && (state == ST_WB);
  assign rf_we      = pc_we && dec_regwrite;
  assign halt       = (state == ST_HALT);
  assign retire_cnt = retire_q;
  assign state_o    = state;

endmodule
